mc_control_fsm: RTL and testbench

Multi-cycle main controller for the RV32I-subset core. It sequences a single shared instruction/data memory port, the register file, and the ALU through fetch, decode, execute, memory and writeback states. It holds a variable-latency memory handshake and counts retired instructions. It sits beside the datapath in place of the combinational control used by the single-cycle build, and drives the datapath select/enable lines each cycle.

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_alu_dec.sv | 25 ++
 rtl/mc_control_fsm.sv | 190 +++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I-subset controller.
// The state enum, opcode constants and datapath select codes live here.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: funct3/funct7b5 to ALU operation.
// Flags funct3 values outside the supported subset as illegal.
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       illegal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        illegal  = 1'b0;
        case (funct3)
            3'b000:  alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: sequences the shared memory port, register
// file and ALU, and counts retired instructions.
//
// state      | meaning
// FETCH      | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE     | OldPC+imm into ALUOut (branch/jal target), dispatch on op
// MEMADR     | rs1+imm effective address for lw/sw
// MEMREAD    | load access, held until mem_ready
// MEMWB      | write load data to rd
// MEMWRITE   | store access, held until mem_ready
// EXECUTER   | register-register ALU op
// EXECUTEI   | register-immediate ALU op
// ALUWB      | write ALUOut to rd
// BRANCH     | compare rs1/rs2, load target from ALUOut if taken
// JAL        | PC <= target, ALUOut <= OldPC+4
// TRAP       | illegal instruction, halted until reset
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  EQ,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  MemWrite,
    output logic                  AdrSrc,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [2:0]            ALUctrl,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ImmSrc,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] instret
);

    state_t     state, state_nxt;
    logic       retire;
    logic       is_rtype;
    logic [2:0] dec_alu;
    logic       dec_illegal;

    assign is_rtype = (state == S_EXECUTER);

    mc_alu_dec u_alu_dec (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (is_rtype),
        .alu_ctrl (dec_alu),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_nxt;
            if (retire)
                instret <= instret + DATA_WIDTH'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUctrl   = ALU_ADD;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_I;
        halted    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready)
                    state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECUTER;
                    OP_I:         state_nxt = S_EXECUTEI;
                    OP_B:         state_nxt = S_BRANCH;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = (op == OP_SW) ? IMM_S : IMM_I;
                state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready)
                    state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_READDATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUctrl   = dec_alu;
                state_nxt = dec_illegal ? S_TRAP : S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                ALUctrl   = dec_alu;
                state_nxt = dec_illegal ? S_TRAP : S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUctrl   = ALU_SUB;
                ResultSrc = RES_ALUOUT;
                // Only beq/bne are supported; anything else traps without touching PC
                case (funct3)
                    3'b000: begin
                        PCWrite   = EQ;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    3'b001: begin
                        PCWrite   = !EQ;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: state_nxt = S_TRAP;
                endcase
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle expected control vectors
// and instret values are queued per instruction, then replayed and compared.
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic        clk, rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5, EQ, mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, halted;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUctrl;
    logic [31:0] instret;
    logic [17:0] obs;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rdy;
        logic        eq;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [17:0] ctrl;
        logic [31:0] ir;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] exp_instret = 0;
    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic        cur_f7;

    mc_control_fsm #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .EQ(EQ), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUctrl(ALUctrl),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .halted(halted), .instret(instret)
    );

    assign obs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUctrl, ResultSrc, ImmSrc, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [17:0] cv(logic mr, logic mw, logic as, logic ir, logic pw,
                                       logic rw, logic [1:0] a, logic [1:0] b,
                                       logic [2:0] alu, logic [1:0] rs, logic [1:0] imm,
                                       logic h);
        return {mr, mw, as, ir, pw, rw, a, b, alu, rs, imm, h};
    endfunction

    // Expected per-state control vectors, straight from the state descriptions
    function automatic logic [17:0] e_fetch(logic r);
        return cv(1, 0, 0, r, r, 0, 2'b00, 2'b10, 3'b000, 2'b10, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_decode(logic j);
        return cv(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b00, j ? 2'b11 : 2'b10, 0);
    endfunction
    function automatic logic [17:0] e_memadr(logic sw);
        return cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, sw ? 2'b01 : 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_memread();
        return cv(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_memwb();
        return cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_memwrite();
        return cv(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_exr(logic [2:0] alu);
        return cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_exi(logic [2:0] alu);
        return cv(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_aluwb();
        return cv(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_branch(logic pw);
        return cv(0, 0, 0, 0, pw, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_jal();
        return cv(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 3'b000, 2'b00, 2'b00, 0);
    endfunction
    function automatic logic [17:0] e_trap();
        return cv(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1);
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void set_instr(logic [6:0] o, logic [2:0] f3, logic f7);
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
    endfunction

    function automatic void push(logic rdy, logic eq, logic [17:0] c);
        ent_t e;
        e.rdy  = rdy;
        e.eq   = eq;
        e.op   = cur_op;
        e.f3   = cur_f3;
        e.f7   = cur_f7;
        e.ctrl = c;
        e.ir   = exp_instret;
        sb.push_back(e);
    endfunction

    task automatic test_reset();
        rst = 1'b0; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; EQ = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mem_req got %b want 1", mem_req); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
        checks++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++;
        if (obs !== e_fetch(1'b0)) begin errors++; $display("FAIL reset_ctrl got %b want %b", obs, e_fetch(1'b0)); end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_instret = 0;
    endtask

    task automatic test_rtype();
        logic [2:0] f3s [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        logic       f7s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] alus[5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        int n = 0;
        ent_t e;
        for (int i = 0; i < 5; i++) begin
            set_instr(OP_R, f3s[i], f7s[i]);
            push(1'b1, rnd(), e_fetch(1'b1));
            push(rnd(), rnd(), e_decode(1'b0));
            push(rnd(), rnd(), e_exr(alus[i]));
            push(rnd(), rnd(), e_aluwb());
            exp_instret++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL rtype_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL rtype_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_itype();
        logic [2:0] f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        logic       f7s [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0] alus[4] = '{3'b000, 3'b101, 3'b011, 3'b010};
        int n = 0;
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            set_instr(OP_I, f3s[i], f7s[i]);
            push(1'b1, rnd(), e_fetch(1'b1));
            push(rnd(), rnd(), e_decode(1'b0));
            push(rnd(), rnd(), e_exi(alus[i]));
            push(rnd(), rnd(), e_aluwb());
            exp_instret++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL itype_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL itype_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
    endtask

    // lw with 3 MEMREAD waits, then sw with 2 FETCH waits and 1 MEMWRITE wait
    task automatic test_mem_wait();
        int n = 0;
        ent_t e;
        set_instr(OP_LW, 3'b010, 1'b0);
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b0));
        push(rnd(), rnd(), e_memadr(1'b0));
        repeat (3) push(1'b0, rnd(), e_memread());
        push(1'b1, rnd(), e_memread());
        push(rnd(), rnd(), e_memwb());
        exp_instret++;
        set_instr(OP_SW, 3'b010, 1'b0);
        repeat (2) push(1'b0, rnd(), e_fetch(1'b0));
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b0));
        push(rnd(), rnd(), e_memadr(1'b1));
        push(1'b0, rnd(), e_memwrite());
        push(1'b1, rnd(), e_memwrite());
        exp_instret++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL mem_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL mem_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_branch_jal();
        logic [2:0] f3s[4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic       eqs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pws[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int n = 0;
        ent_t e;
        for (int i = 0; i < 4; i++) begin
            set_instr(OP_B, f3s[i], 1'b0);
            push(1'b1, rnd(), e_fetch(1'b1));
            push(rnd(), rnd(), e_decode(1'b0));
            push(rnd(), eqs[i], e_branch(pws[i]));
            exp_instret++;
        end
        set_instr(OP_JAL, 3'b101, 1'b1);
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b1));
        push(rnd(), rnd(), e_jal());
        push(rnd(), rnd(), e_aluwb());
        exp_instret++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL brjal_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL brjal_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Illegal op then illegal I-type funct3; TRAP must hold until reset
    task automatic test_trap();
        int n = 0;
        ent_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                set_instr(7'b0000000, 3'b000, 1'b0);
                push(1'b1, rnd(), e_fetch(1'b1));
                push(rnd(), rnd(), e_decode(1'b0));
            end else begin
                set_instr(OP_I, 3'b001, 1'b0);
                push(1'b1, rnd(), e_fetch(1'b1));
                push(rnd(), rnd(), e_decode(1'b0));
                push(rnd(), rnd(), e_exi(3'b000));
            end
            repeat (10) push(rnd(), rnd(), e_trap());
            while (sb.size() > 0) begin
                e = sb.pop_front();
                op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
                @(negedge clk);
                checks++;
                if (obs !== e.ctrl) begin errors++; $display("FAIL trap_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
                checks++;
                if (instret !== e.ir) begin errors++; $display("FAIL trap_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
                @(posedge clk); #1;
                n++;
            end
            rst = 1'b0;
            mem_ready = 1'b0;
            #1;
            checks++;
            if (obs !== e_fetch(1'b0)) begin errors++; $display("FAIL trap_reset_ctrl got %b want %b", obs, e_fetch(1'b0)); end
            checks++;
            if (instret !== 32'd0) begin errors++; $display("FAIL trap_reset_instret got %0d want 0", instret); end
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            exp_instret = 0;
        end
    endtask

    // Reset mid-MEMREAD wait aborts lw with no RegWrite, then an add retires normally
    task automatic test_reset_midwait();
        int n = 0;
        ent_t e;
        set_instr(OP_R, 3'b000, 1'b0);
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b0));
        push(rnd(), rnd(), e_exr(3'b000));
        push(rnd(), rnd(), e_aluwb());
        exp_instret++;
        set_instr(OP_LW, 3'b010, 1'b0);
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b0));
        push(rnd(), rnd(), e_memadr(1'b0));
        repeat (2) push(1'b0, rnd(), e_memread());
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL midwait_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL midwait_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== e_fetch(1'b0)) begin errors++; $display("FAIL midwait_abort_ctrl got %b want %b", obs, e_fetch(1'b0)); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL midwait_abort_instret got %0d want 0", instret); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_instret = 0;
        set_instr(OP_R, 3'b110, 1'b0);
        push(1'b1, rnd(), e_fetch(1'b1));
        push(rnd(), rnd(), e_decode(1'b0));
        push(rnd(), rnd(), e_exr(3'b011));
        push(rnd(), rnd(), e_aluwb());
        exp_instret++;
        push(1'b0, rnd(), e_fetch(1'b0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            op = e.op; funct3 = e.f3; funct7b5 = e.f7; mem_ready = e.rdy; EQ = e.eq;
            @(negedge clk);
            checks++;
            if (obs !== e.ctrl) begin errors++; $display("FAIL resume_ctrl cyc%0d got %b want %b", n, obs, e.ctrl); end
            checks++;
            if (instret !== e.ir) begin errors++; $display("FAIL resume_instret cyc%0d got %0d want %0d", n, instret, e.ir); end
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem_wait();
        test_branch_jal();
        test_trap();
        test_reset_midwait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
